// File: rtl/demux4_buf.sv
// demux4_buf: 1-to-4 demultiplexer with a 2-entry FIFO per output lane.
//
// One producer pushes a WIDTH-bit beat per cycle (valid/ready) tagged with a
// 2-bit lane select. Each of the four lanes buffers up to two beats and drains
// independently to its own consumer (valid/ready). in_ready depends only on the
// presented in_sel and registered lane counts, so there is no
// combinational path from out_ready or in_data to any output.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_data/in_sel    input beat and destination lane
//   in_valid/in_ready input handshake (in_ready = selected lane not full)
//   out_data          lane k data at [k*WIDTH +: WIDTH]
//   out_valid[k]      lane k head valid
//   out_ready[k]      consumer k takes lane k head this cycle
//   beat_cnt          (DEMUX_BEATCNT_EN only) per-lane 8-bit push counters,
//                     lane k at [k*8 +: 8], wrap 255 -> 0
//
// Optional feature macro: DEMUX_BEATCNT_EN

// One lane: 2-entry FIFO. count 0 = idle, 1/2 = occupied.
module demux4_buf_lane #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,        // already gated by !full at the top
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);
    logic [1:0]            count_q, count_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0][WIDTH-1:0] mem_q, mem_d;
    logic                  pop;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        // Pop at count 0 is ignored, so a push into an empty lane with the
        // consumer ready still lands (count -> 1).
        pop = (count_q != 2'd0) && pop_ready;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;  // idle, or push+pop at count 1
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            mem_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign full       = (count_q == 2'd2);
    assign head_valid = (count_q != 2'd0);
    assign head_data  = mem_q[rd_ptr_q];
endmodule

module demux4_buf #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [1:0]         in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_valid,
    input  logic [3:0]         out_ready
`ifdef DEMUX_BEATCNT_EN
    ,
    output logic [4*8-1:0]     beat_cnt
`endif
);
    logic [3:0]            lane_full;
    logic [3:0]            push_vec;
    logic [3:0][WIDTH-1:0] lane_data;

    // Full lane blocks the push even if its consumer pops this cycle.
    assign in_ready = ~lane_full[in_sel];

    always_comb begin
        push_vec         = '0;
        push_vec[in_sel] = in_valid & in_ready;
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        demux4_buf_lane #(.WIDTH(WIDTH)) u_lane (
            .clk        (clk),
            .rst        (reset),
            .push       (push_vec[k]),
            .push_data  (in_data),
            .pop_ready  (out_ready[k]),
            .full       (lane_full[k]),
            .head_valid (out_valid[k]),
            .head_data  (lane_data[k])
        );
    end

    assign out_data = lane_data;

`ifdef DEMUX_BEATCNT_EN
    logic [3:0][7:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            beat_cnt_d[k] = beat_cnt_q[k] + {7'd0, push_vec[k]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) beat_cnt_q <= '0;
        else       beat_cnt_q <= beat_cnt_d;
    end

    assign beat_cnt = beat_cnt_q;
`endif
endmodule
